// File: rtl/alsu_if.sv
// alsu_if: command and result bundle between the harness driver and alsu_pipe
interface alsu_if #(parameter int WIDTH = 8, parameter int LED_W = 16);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] A, B;
  logic cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [2:0] opcode;
  logic out_valid, err;
  logic [2*WIDTH-1:0] out;
  logic [LED_W-1:0] leds;
  modport master (output in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode, bypass_A, bypass_B, direction,
                  input in_ready, out_valid, out, err, leds);
  modport slave (input in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode, bypass_A, bypass_B, direction,
                 output in_ready, out_valid, out, err, leds);
endinterface

// File: rtl/alsu_pipe.sv
// alsu_pipe: handshaked signed ALSU with an iterative shift-add multiplier
module alsu_pipe #(
  parameter int WIDTH = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER = "ON",
  parameter int LED_W = 16
) (
  input logic clk,
  input logic rst_n,
  alsu_if.slave bus
);
  localparam int OUT_W = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam bit PRI_A = INPUT_PRIORITY == "A";
  localparam bit USE_CIN = FULL_ADDER == "ON";
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t st;
  logic [WIDTH-1:0] a_r, b_r, mp, ma, mb, rsrc;
  logic [2:0] op_r;
  logic cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r, neg, inv, go_mul;
  logic [OUT_W-1:0] mc, acc, ax, bx, res;
  logic [CW-1:0] cnt;
  assign bus.in_ready = st == IDLE;
  // multiplier operand magnitudes and the decision to take the multi-cycle path
  always_comb begin
    ma = bus.A[WIDTH-1] ? -bus.A : bus.A;
    mb = bus.B[WIDTH-1] ? -bus.B : bus.B;
    go_mul = bus.opcode == 3'd3 && !bus.red_op_A && !bus.red_op_B && !bus.bypass_A && !bus.bypass_B;
  end
  // single-cycle result from the captured command; shift/rotate act on the held out register
  always_comb begin
    ax = {{WIDTH{a_r[WIDTH-1]}}, a_r};
    bx = {{WIDTH{b_r[WIDTH-1]}}, b_r};
    inv = ((ra_r | rb_r) & (op_r[2] | op_r[1])) | (op_r[2] & op_r[1]);
    rsrc = (ra_r & rb_r) ? (PRI_A ? a_r : b_r) : ra_r ? a_r : b_r;
    res = inv ? '0
        : (ba_r & bb_r) ? (PRI_A ? ax : bx)
        : ba_r ? ax
        : bb_r ? bx
        : op_r == 3'd0 ? ((ra_r | rb_r) ? OUT_W'(|rsrc) : ax | bx)
        : op_r == 3'd1 ? ((ra_r | rb_r) ? OUT_W'(^rsrc) : ax ^ bx)
        : op_r == 3'd2 ? ax + bx + OUT_W'(USE_CIN & cin_r)
        : op_r == 3'd4 ? (dir_r ? {bus.out[OUT_W-2:0], si_r} : {si_r, bus.out[OUT_W-1:1]})
        : op_r == 3'd5 ? (dir_r ? {bus.out[OUT_W-2:0], bus.out[OUT_W-1]} : {bus.out[0], bus.out[OUT_W-1:1]})
        : '0;
  end
  // control FSM: capture, single-cycle execute or WIDTH-step multiply, then one-cycle result pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      {a_r, b_r, op_r, cin_r, si_r, ra_r, rb_r, ba_r, bb_r, dir_r} <= '0;
      {mc, acc, mp, cnt, neg} <= '0;
      bus.out_valid <= 1'b0;
      bus.out <= '0;
      bus.err <= 1'b0;
      bus.leds <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (st == IDLE && bus.in_valid) begin
        {a_r, b_r, op_r} <= {bus.A, bus.B, bus.opcode};
        {cin_r, si_r, ra_r, rb_r} <= {bus.cin, bus.serial_in, bus.red_op_A, bus.red_op_B};
        {ba_r, bb_r, dir_r} <= {bus.bypass_A, bus.bypass_B, bus.direction};
        mc <= {{WIDTH{1'b0}}, ma};
        mp <= mb;
        acc <= '0;
        cnt <= '0;
        neg <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        st <= go_mul ? MUL : EXEC;
      end else if (st == EXEC) begin
        bus.out <= res;
        bus.err <= inv;
        bus.leds <= inv ? ~bus.leds : '0;
        bus.out_valid <= 1'b1;
        st <= IDLE;
      end else if (st == MUL) begin
        acc <= mp[0] ? acc + mc : acc;
        mc <= mc << 1;
        mp <= mp >> 1;
        cnt <= cnt + 1'b1;
        st <= cnt == CW'(WIDTH - 1) ? DONE : MUL;
      end else if (st == DONE) begin
        bus.out <= neg ? -acc : acc;
        bus.err <= 1'b0;
        bus.leds <= '0;
        bus.out_valid <= 1'b1;
        st <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: scoreboard bench for two alsu_pipe variants driven by one command stream
module tb_alsu_pipe;
  localparam int W = 8;
  typedef struct {
    logic [7:0] a, b;
    logic cin, si, ra, rb, ba, bb, dir;
    logic [2:0] op;
  } cmd_t;
  typedef struct {
    logic [15:0] out;
    logic err;
    logic [15:0] leds;
    int cyc;
  } exp_t;
  logic clk = 0, rst_n, in_valid;
  cmd_t cur;
  int cyc = 0, n_chk = 0, n_fail = 0, n_ov0 = 0, n_ov1 = 0, n_exp = 0;
  exp_t q0[$], q1[$];
  logic [15:0] mout[2], mleds[2];
  alsu_if #(.WIDTH(W), .LED_W(16)) if0 ();
  alsu_if #(.WIDTH(W), .LED_W(16)) if1 ();
  assign {if0.in_valid, if0.A, if0.B, if0.cin, if0.serial_in, if0.red_op_A, if0.red_op_B, if0.opcode, if0.bypass_A, if0.bypass_B, if0.direction} =
         {in_valid, cur.a, cur.b, cur.cin, cur.si, cur.ra, cur.rb, cur.op, cur.ba, cur.bb, cur.dir};
  assign {if1.in_valid, if1.A, if1.B, if1.cin, if1.serial_in, if1.red_op_A, if1.red_op_B, if1.opcode, if1.bypass_A, if1.bypass_B, if1.direction} =
         {in_valid, cur.a, cur.b, cur.cin, cur.si, cur.ra, cur.rb, cur.op, cur.ba, cur.bb, cur.dir};
  alsu_pipe #(.WIDTH(W)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: instance 0 is priority A with carry, instance 1 priority B without carry
  task automatic predict(int i, cmd_t c, int ac);
    exp_t e;
    int sa, sb, r;
    logic [7:0] src;
    logic pa, inv, byp;
    pa = i == 0;
    sa = int'($signed(c.a));
    sb = int'($signed(c.b));
    byp = c.ba || c.bb;
    inv = ((c.ra || c.rb) && c.op >= 3'd2) || c.op >= 3'd6;
    e.cyc = ac + ((c.op == 3'd3 && !inv && !byp) ? W + 1 : 1);
    e.err = inv;
    if (inv) begin
      e.out = 16'h0;
      mleds[i] = ~mleds[i];
    end else begin
      mleds[i] = 16'h0;
      src = (c.ra && c.rb) ? (pa ? c.a : c.b) : (c.ra ? c.a : c.b);
      r = 0;
      if (byp) r = (c.ba && c.bb) ? (pa ? sa : sb) : (c.ba ? sa : sb);
      else if (c.op == 3'd0) r = (c.ra || c.rb) ? int'(src != 0) : (sa | sb);
      else if (c.op == 3'd1) r = (c.ra || c.rb) ? $countones(src) % 2 : (sa ^ sb);
      else if (c.op == 3'd2) r = sa + sb + (pa ? int'(c.cin) : 0);
      else if (c.op == 3'd3) r = sa * sb;
      e.out = 16'(r);
      if (!byp && c.op == 3'd4) e.out = c.dir ? {mout[i][14:0], c.si} : {c.si, mout[i][15:1]};
      if (!byp && c.op == 3'd5) e.out = c.dir ? {mout[i][14:0], mout[i][15]} : {mout[i][0], mout[i][15:1]};
    end
    mout[i] = e.out;
    e.leds = mleds[i];
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(int i, logic [15:0] o, logic er, logic [15:0] l);
    exp_t e;
    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_valid%0d: got out_valid=1 expected 0", i);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("out%0d", i), 32'(o), 32'(e.out));
    chk($sformatf("err%0d", i), 32'(er), 32'(e.err));
    chk($sformatf("leds%0d", i), 32'(l), 32'(e.leds));
    chk($sformatf("latency%0d", i), cyc, e.cyc);
  endtask

  // monitor: every result pulse is matched against the oldest prediction
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if0.out_valid) begin
      n_ov0++;
      mon(0, if0.out, if0.err, if0.leds);
    end
    if (rst_n === 1'b1 && if1.out_valid) begin
      n_ov1++;
      mon(1, if1.out, if1.err, if1.leds);
    end
  end

  function automatic cmd_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic cin = 0, logic ra = 0,
                              logic rb = 0, logic ba = 0, logic bb = 0, logic dir = 0, logic si = 0);
    cmd_t c;
    c.op = op; c.a = a; c.b = b; c.cin = cin; c.ra = ra; c.rb = rb;
    c.ba = ba; c.bb = bb; c.dir = dir; c.si = si;
    return c;
  endfunction

  function automatic cmd_t rnd();
    return mk(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              1'($urandom), 1'($urandom));
  endfunction

  // waits for in_ready while poking ignored commands, then issues c and records its predictions
  task automatic send(cmd_t c);
    int t = 0;
    @(negedge clk);
    while (!if0.in_ready && t < 100) begin
      cur = rnd();
      in_valid = 1'($urandom);
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      $display("FAIL ready_timeout: got in_ready=0 expected 1");
      $fatal(1, "in_ready stuck low");
    end
    cur = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    predict(0, c, cyc);
    predict(1, c, cyc);
    n_exp++;
  endtask

  initial begin
    int n, t;
    rst_n = 1'b1;
    in_valid = 1'b0;
    cur = mk(0, 0, 0);
    mout = '{16'h0, 16'h0};
    mleds = '{16'h0, 16'h0};
    #2 rst_n = 1'b0;
    #4;
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_out", 32'(if0.out), 0);
    chk("rst_err", 32'(if0.err), 0);
    chk("rst_leds", 32'(if0.leds), 0);
    chk("rst_out1", 32'(if1.out), 0);
    @(negedge clk) rst_n = 1'b1;
    send(mk(2, 8'd127, 8'd127, 1));
    send(mk(3, -8'sd3, 8'd5));
    n = 0;
    @(negedge clk);
    while (!if0.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", n, W + 1);
    send(mk(3, 8'h80, 8'h80));
    send(mk(6, 0, 0));
    send(mk(0, 0, 8'h5a, 0, 1));
    send(mk(7, 1, 2));
    send(mk(4, 1, 2, 0, 1));
    send(mk(0, 1, 0, 0, 0, 0, 1));
    send(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    send(mk(5, 0, 0));
    send(mk(3, -8'sd2, 8'd3, 0, 0, 0, 1, 1));
    send(mk(1, 8'h07, 8'h80, 0, 1, 1));
    send(mk(3, 8'h7f, 8'h81));
    repeat (3) begin
      send(mk(3, 8'd9, -8'sd7));
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(if0.in_ready), 1);
      chk("abort_out", 32'(if0.out), 0);
      chk("abort_out_valid", 32'(if0.out_valid), 0);
      q0.delete();
      q1.delete();
      n_exp--;
      mout = '{16'h0, 16'h0};
      mleds = '{16'h0, 16'h0};
      @(negedge clk) rst_n = 1'b1;
      repeat (12) @(negedge clk);
      send(rnd());
    end
    for (int k = 0; k < 400; k++) send(rnd());
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    chk("count0", n_ov0, n_exp);
    chk("count1", n_ov1, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
Parametrised, handshaked successor to the team's 3-bit ALSU. It executes the same opcode set on signed WIDTH-bit operands and produces a 2*WIDTH-bit result. Multiply is a multi-cycle iterative shift-add, and every result is qualified by out_valid. It sits between the test-harness command driver and the result checker/LED panel.

Parameters:
WIDTH, 8, operand width in bits (>=2); result width OUT_W = 2*WIDTH
INPUT_PRIORITY, "A", operand selected when both bypass or both reduction flags are set ("A" or "B")
FULL_ADDER, "ON", "ON" adds cin in opcode 2; "OFF" ignores cin
LED_W, 16, width of leds output

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
in_valid  input  1  command valid
in_ready  output  1  block can accept a command
A  input  WIDTH  signed operand A
B  input  WIDTH  signed operand B
cin  input  1  carry in
serial_in  input  1  serial bit for opcode 4
red_op_A  input  1  reduction on A
red_op_B  input  1  reduction on B
opcode  input  3  operation select
bypass_A  input  1  pass A through
bypass_B  input  1  pass B through
direction  input  1  1 = left, 0 = right (opcodes 4/5)
out_valid  output  1  one-cycle pulse, result valid
out  output  OUT_W  signed result, held between pulses
err  output  1  result is from an invalid command; valid only with out_valid
leds  output  LED_W  invalid-command indicator

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, out=0, err=0, leds=0, all captured command registers 0. Reset mid-multiply aborts the operation with no out_valid.
- FSM states: IDLE, EXEC, MUL, DONE. in_ready = (state==IDLE). in_valid is ignored when in_ready=0.
- Capture: in_valid && in_ready at edge k latches all command inputs. If opcode is 3, the command is valid and no bypass is set, go to MUL; otherwise go to EXEC.
- EXEC: at edge k+1, out/err update, out_valid=1 for that one cycle, return to IDLE. Throughput is one command per 2 cycles.
- MUL: signed magnitudes are multiplied unsigned by shift-add, one multiplier bit per cycle. The WIDTH iterations run on edges k+1..k+WIDTH. DONE applies the sign and presents the result at edge k+WIDTH+1 with out_valid=1, then returns to IDLE.
- Invalid when either condition holds:
  - (red_op_A|red_op_B) && (opcode[2]|opcode[1])
  - opcode is 6 or 7
- Invalid command: out=0, err=1, leds <= ~leds. Any valid result sets err=0 and leds=0.
- Priority for a valid command: both bypass flags -> INPUT_PRIORITY operand; else bypass_A -> A; else bypass_B -> B; else opcode. Bypass overrides opcode 3, so no MUL is entered.
- Operand extension: A/B are sign-extended to OUT_W for bypass, OR, XOR and add.
- Opcodes:
  - 0: OR. If reduction flags are set, result is |operand (INPUT_PRIORITY if both), zero-extended.
  - 1: XOR. Same rules, using ^.
  - 2: A+B+cin (cin only if FULL_ADDER="ON"); exact in OUT_W, no overflow possible.
  - 3: signed A*B, exact in OUT_W; -2^(WIDTH-1) squared is representable.
  - 4: shift the current out register. direction=1 gives {out[OUT_W-2:0],serial_in}; direction=0 gives {serial_in,out[OUT_W-1:1]}.
  - 5: rotate the current out register. Left is {out[OUT_W-2:0],out[OUT_W-1]}; right is {out[0],out[OUT_W-1:1]}.
- out changes only on out_valid cycles or reset.

Test Plan:
- WIDTH=8, opcode 2, A=127, B=127, cin=1 -> out=0x00FF after 1 cycle, err=0; repeat with FULL_ADDER="OFF" -> 0x00FE.
- Opcode 3, A=-3, B=5 -> in_ready low for 9 cycles, out_valid at edge k+9, out=0xFFF1. A=-128, B=-128 -> 0x4000.
- Opcode 6, then opcode 0 with red_op_A=1 and A=0 (valid) -> leds 0xFFFF with err=1, then leds 0x0000 with out=0 and err=0. Two consecutive invalids -> leds 0xFFFF then 0x0000, err=1 both times.
- out=0x0001, opcode 4, direction=1, serial_in=1 -> 0x0003; then opcode 5, direction=0 -> 0x8001.
- bypass_A=bypass_B=1, A=-2, B=3, INPUT_PRIORITY="B" -> out=0x0003 in 1 cycle, opcode 3 ignored.
- rst_n low at MUL cycle 4 -> no out_valid, out=0, in_ready=1 immediately. in_valid during MUL -> ignored; command count matches out_valid count.
